// File: rtl/write_back_stream_pkg.sv
// Shared types and helpers for the psum write-back stream stage.
// Modes, FSM states and the ReLU/saturate byte conversion live here.
package write_back_stream_pkg;

  localparam int PSUM_WIDTH                  = 16;
  localparam int FM_GUARD_GEN_PSUM_BUF_DEPTH = 64;
  localparam int WB_BYTE_W                   = 8;

  typedef enum logic [1:0] {
    WB_DENSE  = 2'd0,
    WB_SPARSE = 2'd1,
    WB_DIFF   = 2'd2
  } wb_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_GUARD,
    S_EMIT,
    S_NEXT,
    S_DONE
  } wb_state_t;

  // Callers sign-extend their psum to 32 bits before calling.
  function automatic logic [WB_BYTE_W-1:0] relu_sat(input logic signed [31:0] v);
    if (v < 0)
      return '0;
    else if (v > 255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/write_back_stream_if.sv
// Bus bundle for the write-back stage: job control, psum read port,
// feature-map byte stream and guard-map stream.
interface write_back_stream_if
  import write_back_stream_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int PSUM_W = PSUM_WIDTH,
  parameter int ADDR_W = $clog2(FM_GUARD_GEN_PSUM_BUF_DEPTH)
);

  logic                       ctrl_valid;
  logic                       ctrl_ready;
  logic                       ctrl_finish;
  logic [ADDR_W-1:0]          stop_addr_i;
  logic [1:0]                 mode_i;
  logic                       rd_en;
  logic [ADDR_W-1:0]          addr_o;
  logic [NUM_CH*PSUM_W-1:0]   data_i;
  logic [WB_BYTE_W-1:0]       data_o;
  logic                       data_o_valid;
  logic                       data_o_ready;
  logic [NUM_CH-1:0]          guard_o;
  logic                       guard_o_valid;
  logic                       guard_o_ready;

  modport master (
    input  ctrl_valid, stop_addr_i, mode_i, data_i, data_o_ready, guard_o_ready,
    output ctrl_ready, ctrl_finish, rd_en, addr_o, data_o, data_o_valid,
           guard_o, guard_o_valid
  );

  modport slave (
    output ctrl_valid, stop_addr_i, mode_i, data_i, data_o_ready, guard_o_ready,
    input  ctrl_ready, ctrl_finish, rd_en, addr_o, data_o, data_o_valid,
           guard_o, guard_o_valid
  );

endinterface

// File: rtl/write_back_stream_lead_one.sv
// Lowest-set-bit finder: one-hot and index of the first remaining channel
// in the emit mask, plus a flag saying whether any bit is left.
module write_back_stream_lead_one #(
  parameter int NUM_CH = 6,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] onehot,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    onehot = mask & (~mask + NUM_CH'(1));
    any    = |mask;
    idx    = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mask[c])
        idx = IDX_W'(c);
    end
  end

endmodule

// File: rtl/write_back_stream.sv
// Write-back stage: sweeps psum rows 0..stop, applies ReLU/saturation, sends a
// per-row guard map and streams dense, sparse or nibble-packed diff bytes.
module write_back_stream
  import write_back_stream_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int PSUM_W = PSUM_WIDTH,
  parameter int ADDR_W = $clog2(FM_GUARD_GEN_PSUM_BUF_DEPTH),
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  write_back_stream_if.master bus
);

  localparam int         IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  wb_state_t             state;
  wb_mode_t              mode;
  logic                  pass_lo;
  logic [ADDR_W-1:0]     row;
  logic [ADDR_W-1:0]     stop;
  logic [1:0]            wait_cnt;
  logic [NUM_CH-1:0]     mask;

  logic signed [PSUM_W-1:0] row_q [NUM_CH];
  logic [WB_BYTE_W-1:0]     val   [NUM_CH];
  logic [NUM_CH-1:0]        guard_bits;
  logic [NUM_CH-1:0]        oh1, oh2, consumed;
  logic [IDX_W-1:0]         idx1, idx2;
  logic                     any1, any2;
  logic [WB_BYTE_W-1:0]     next_byte;
  logic                     latch;

  assign latch = (state == S_WAIT) && (wait_cnt == LAT_LAST);

  // Row register: psum data arrives RD_LAT cycles after the fetch strobe
  always_ff @(posedge clk) begin
    if (latch) begin
      for (int c = 0; c < NUM_CH; c++)
        row_q[c] <= $signed(bus.data_i[c*PSUM_W +: PSUM_W]);
    end
  end

  always_comb begin
    guard_bits = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      val[c] = relu_sat(32'(row_q[c]));
      case (mode)
        WB_SPARSE: guard_bits[c] = (val[c] != '0);
        WB_DIFF:   guard_bits[c] = pass_lo ? ((val[c] != '0) && (val[c][7:4] == 4'h0))
                                           : (val[c][7:4] != 4'h0);
        default:   guard_bits[c] = 1'b0;
      endcase
    end
  end

  write_back_stream_lead_one #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_lead1 (
    .mask   (mask),
    .onehot (oh1),
    .idx    (idx1),
    .any    (any1)
  );

  write_back_stream_lead_one #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_lead2 (
    .mask   (mask & ~oh1),
    .onehot (oh2),
    .idx    (idx2),
    .any    (any2)
  );

  // Diff low pass packs two small residues per byte, first one in the low nibble
  always_comb begin
    next_byte = val[idx1];
    consumed  = oh1;
    if (mode == WB_DIFF && pass_lo) begin
      next_byte = {any2 ? val[idx2][3:0] : 4'h0, val[idx1][3:0]};
      consumed  = oh1 | oh2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      mode              <= WB_DENSE;
      pass_lo           <= 1'b0;
      row               <= '0;
      stop              <= '0;
      wait_cnt          <= '0;
      mask              <= '0;
      bus.ctrl_ready    <= 1'b1;
      bus.ctrl_finish   <= 1'b0;
      bus.rd_en         <= 1'b0;
      bus.addr_o        <= '0;
      bus.data_o        <= '0;
      bus.data_o_valid  <= 1'b0;
      bus.guard_o       <= '0;
      bus.guard_o_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ctrl_valid && bus.ctrl_ready) begin
            bus.ctrl_ready <= 1'b0;
            stop           <= bus.stop_addr_i;
            mode           <= (bus.mode_i == 2'd3) ? WB_DENSE : wb_mode_t'(bus.mode_i);
            pass_lo        <= 1'b0;
            row            <= '0;
            bus.addr_o     <= '0;
            bus.rd_en      <= 1'b1;
            state          <= S_FETCH;
          end
        end
        S_FETCH: begin
          bus.rd_en <= 1'b0;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (latch) begin
            if (mode == WB_DENSE) begin
              mask  <= '1;
              state <= S_EMIT;
            end else begin
              state <= S_GUARD;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_GUARD: begin
          if (!bus.guard_o_valid) begin
            bus.guard_o       <= guard_bits;
            bus.guard_o_valid <= 1'b1;
            mask              <= guard_bits;
          end else if (bus.guard_o_ready) begin
            bus.guard_o_valid <= 1'b0;
            state             <= any1 ? S_EMIT : S_NEXT;
          end
        end
        S_EMIT: begin
          if (!bus.data_o_valid || bus.data_o_ready) begin
            if (any1) begin
              bus.data_o       <= next_byte;
              bus.data_o_valid <= 1'b1;
              mask             <= mask & ~consumed;
            end else begin
              bus.data_o_valid <= 1'b0;
              state            <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (row == stop) begin
            if (mode == WB_DIFF && !pass_lo) begin
              pass_lo    <= 1'b1;
              row        <= '0;
              bus.addr_o <= '0;
              bus.rd_en  <= 1'b1;
              state      <= S_FETCH;
            end else begin
              bus.ctrl_finish <= 1'b1;
              state           <= S_DONE;
            end
          end else begin
            row        <= row + ADDR_W'(1);
            bus.addr_o <= row + ADDR_W'(1);
            bus.rd_en  <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_DONE: begin
          bus.ctrl_finish <= 1'b0;
          bus.ctrl_ready  <= 1'b1;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_back_stream.sv
// Bench for write_back_stream: hand-derived vector table, backpressure and
// reset sequences, then randomized jobs against a behavioural stream model.
module tb_write_back_stream;

  localparam int NCH = 6;
  localparam int PW  = 16;
  localparam int AW  = 6;
  localparam int LAT = 2;

  typedef struct packed {
    logic [1:0]            mode;
    logic [5:0]            stop;
    logic [0:5][15:0]      row0;
    logic [0:5][15:0]      row1;
    logic [4:0]            n;
    logic [0:11][8:0]      ev;   // {1=guard/0=data, payload}
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  write_back_stream_if #(.NUM_CH(NCH), .PSUM_W(PW), .ADDR_W(AW)) bus ();

  write_back_stream #(.NUM_CH(NCH), .PSUM_W(PW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [PW-1:0] mem [64][NCH];
  logic [NCH*PW-1:0]    pipe [LAT];
  logic [8:0]           log_q [$];
  logic [8:0]           exp_q [$];
  int                   fin_cnt = 0;
  int                   fin_evn = 0;
  logic                 d_hold = 1'b0, g_hold = 1'b0, prev_fin = 1'b0;
  logic [7:0]           d_last = '0;
  logic [NCH-1:0]       g_last = '0;
  logic                 manual = 1'b0, bp_mode = 1'b0, man_d = 1'b1, man_g = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NCH*PW-1:0] row_word(input int a);
    logic [NCH*PW-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*PW +: PW] = mem[a][c];
    return w;
  endfunction

  // Psum buffer model: read data appears LAT cycles after the strobe, junk otherwise
  always @(posedge clk) begin
    pipe[0] <= bus.rd_en ? row_word(int'(bus.addr_o)) : {$urandom, $urandom, $urandom};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.data_i = pipe[LAT-1];

  always @(posedge clk) begin
    #1;
    if (manual) begin
      bus.data_o_ready  = man_d;
      bus.guard_o_ready = man_g;
    end else if (bp_mode) begin
      bus.data_o_ready  = ($urandom_range(0, 2) != 0);
      bus.guard_o_ready = ($urandom_range(0, 3) == 0);
    end else begin
      bus.data_o_ready  = 1'b1;
      bus.guard_o_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      d_hold   = 1'b0;
      g_hold   = 1'b0;
      prev_fin = 1'b0;
    end else begin
      if (d_hold) begin
        check("data_stall_valid", bus.data_o_valid, 1);
        check("data_stall_value", bus.data_o, d_last);
      end
      if (g_hold) begin
        check("guard_stall_valid", bus.guard_o_valid, 1);
        check("guard_stall_value", bus.guard_o, g_last);
      end
      check("guard_data_exclusive", bus.data_o_valid & bus.guard_o_valid, 0);
      if (prev_fin) check("ready_after_finish", bus.ctrl_ready, 1);
      if (bus.ctrl_finish) begin
        fin_cnt++;
        fin_evn = log_q.size();
      end
      if (bus.guard_o_valid && bus.guard_o_ready) log_q.push_back({3'b100, bus.guard_o});
      if (bus.data_o_valid && bus.data_o_ready)   log_q.push_back({1'b0, bus.data_o});
      d_hold   = bus.data_o_valid && !bus.data_o_ready;
      d_last   = bus.data_o;
      g_hold   = bus.guard_o_valid && !bus.guard_o_ready;
      g_last   = bus.guard_o;
      prev_fin = bus.ctrl_finish;
    end
  end

  function automatic int relu(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  // Expected event stream straight from the mode rules
  function automatic void model(input int mode, input int stop);
    int m, passes, v, g;
    int sel [$];
    bit s;
    exp_q.delete();
    m = (mode == 3) ? 0 : mode;
    passes = (m == 2) ? 2 : 1;
    for (int p = 0; p < passes; p++) begin
      for (int r = 0; r <= stop; r++) begin
        sel.delete();
        g = 0;
        for (int c = 0; c < NCH; c++) begin
          v = relu(int'(mem[r][c]));
          if (m == 0) s = 1'b1;
          else if (m == 1) s = (v != 0);
          else if (p == 0) s = (v >= 16);
          else s = (v > 0) && (v < 16);
          if (s) begin
            g = g | (1 << c);
            sel.push_back(v);
          end
        end
        if (m != 0) exp_q.push_back(9'(256 + g));
        if (m == 2 && p == 1) begin
          for (int i = 0; i < sel.size(); i += 2)
            exp_q.push_back(9'(sel[i] + 16 * ((i + 1 < sel.size()) ? sel[i+1] : 0)));
        end else begin
          foreach (sel[i]) exp_q.push_back(9'(sel[i]));
        end
      end
    end
  endfunction

  function automatic logic signed [15:0] rand_psum();
    int v;
    case ($urandom_range(0, 4))
      0:       v = -int'($urandom_range(1, 1000));
      1:       v = 0;
      2:       v = int'($urandom_range(1, 15));
      3:       v = int'($urandom_range(16, 255));
      default: v = int'($urandom_range(256, 32767));
    endcase
    return 16'(v);
  endfunction

  task automatic start_job(input int mode, input int stop);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!bus.ctrl_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.mode_i      = 2'(mode);
    bus.stop_addr_i = 6'(stop);
    bus.ctrl_valid  = 1'b1;
    @(posedge clk); #1;
    bus.ctrl_valid  = 1'b0;
  endtask

  task automatic wait_finish(input int f0);
    int n;
    n = 0;
    while (fin_cnt == f0 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    check("finish_seen", (fin_cnt != f0), 1);
    repeat (4) @(posedge clk);
    check("finish_once", fin_cnt - f0, 1);
  endtask

  task automatic run_job(input int mode, input int stop);
    int f0;
    log_q.delete();
    f0 = fin_cnt;
    start_job(mode, stop);
    wait_finish(f0);
  endtask

  task automatic compare_log(input string name);
    check({name, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check({name, "_event"}, log_q[i], exp_q[i]);
    check({name, "_events_before_finish"}, fin_evn, exp_q.size());
  endtask

  initial begin
    vec_t tbl [5];
    logic [0:5][15:0] r_a, r_b, r_c, r_z, r_e;
    int f0, n;

    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    logic [0:5][15:0] r_a, r_b, r_c, r_z, r_e;
    int f0, n;

    r_a = '{16'd1, -16'sd5, 16'd300, 16'd0, 16'd16, 16'd255};
    r_c = '{16'h12, 16'h03, 16'h00, 16'h0A, 16'h40, 16'h05};
    r_z = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    r_b = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7};
    r_e = '{16'd256, -16'sd1, 16'd128, 16'd2, 16'd0, -16'sd300};

    tbl[0] = '{mode: 2'd0, stop: 6'd1, row0: r_a, row1: r_a, n: 5'd12,
               ev: '{9'h001, 9'h000, 9'h0FF, 9'h000, 9'h010, 9'h0FF,
                     9'h001, 9'h000, 9'h0FF, 9'h000, 9'h010, 9'h0FF}};
    tbl[1] = '{mode: 2'd1, stop: 6'd1, row0: r_a, row1: r_a, n: 5'd10,
               ev: '{9'h135, 9'h001, 9'h0FF, 9'h010, 9'h0FF,
                     9'h135, 9'h001, 9'h0FF, 9'h010, 9'h0FF, 9'h000, 9'h000}};
    tbl[2] = '{mode: 2'd2, stop: 6'd0, row0: r_c, row1: r_z, n: 5'd6,
               ev: '{9'h111, 9'h012, 9'h040, 9'h12A, 9'h0A3, 9'h005,
                     9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000}};
    tbl[3] = '{mode: 2'd1, stop: 6'd1, row0: r_z, row1: r_b, n: 5'd3,
               ev: '{9'h100, 9'h120, 9'h007, 9'h000, 9'h000, 9'h000,
                     9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000}};
    tbl[4] = '{mode: 2'd3, stop: 6'd0, row0: r_e, row1: r_z, n: 5'd6,
               ev: '{9'h0FF, 9'h000, 9'h080, 9'h002, 9'h000, 9'h000,
                     9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000}};

    bus.ctrl_valid  = 1'b0;
    bus.mode_i      = 2'd0;
    bus.stop_addr_i = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_ctrl_ready",   bus.ctrl_ready, 1);
    check("reset_ctrl_finish",  bus.ctrl_finish, 0);
    check("reset_rd_en",        bus.rd_en, 0);
    check("reset_data_valid",   bus.data_o_valid, 0);
    check("reset_guard_valid",  bus.guard_o_valid, 0);
    check("reset_addr",         bus.addr_o, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Hand-derived vectors, both outputs always ready
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < NCH; c++) begin
        mem[0][c] = tbl[i].row0[c];
        mem[1][c] = tbl[i].row1[c];
      end
      run_job(int'(tbl[i].mode), int'(tbl[i].stop));
      exp_q.delete();
      for (int k = 0; k < int'(tbl[i].n); k++) exp_q.push_back(tbl[i].ev[k]);
      compare_log($sformatf("vec%0d", i));
    end

    // Guard stalled five cycles, then random data backpressure; ctrl_valid while busy ignored
    for (int c = 0; c < NCH; c++) begin
      mem[0][c] = r_a[c];
      mem[1][c] = r_a[c];
    end
    manual = 1'b1; man_d = 1'b1; man_g = 1'b0;
    log_q.delete();
    f0 = fin_cnt;
    start_job(1, 1);
    bus.mode_i = 2'd2;
    bus.ctrl_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.ctrl_valid = 1'b0;
    n = 0;
    while (!bus.guard_o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_guard_valid", bus.guard_o_valid, 1);
    repeat (5) @(negedge clk);
    check("bp_guard_held", bus.guard_o_valid, 1);
    check("bp_guard_value", bus.guard_o, 6'h35);
    check("bp_nothing_accepted", log_q.size(), 0);
    manual = 1'b0; bp_mode = 1'b1;
    wait_finish(f0);
    model(1, 1);
    compare_log("bp");
    repeat (5) @(posedge clk);
    check("busy_valid_ignored", bus.ctrl_ready, 1);
    bp_mode = 1'b0;

    // Reset in the middle of a stalled emit, then a fresh job
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NCH; c++) mem[r][c] = 16'($urandom_range(1, 255));
    manual = 1'b1; man_d = 1'b0; man_g = 1'b1;
    log_q.delete();
    f0 = fin_cnt;
    start_job(1, 3);
    n = 0;
    while (!bus.data_o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_emit", bus.data_o_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_ready",       bus.ctrl_ready, 1);
    check("rst_mid_data_valid",  bus.data_o_valid, 0);
    check("rst_mid_data",        bus.data_o, 0);
    check("rst_mid_guard_valid", bus.guard_o_valid, 0);
    check("rst_mid_guard",       bus.guard_o, 0);
    check("rst_mid_rd_en",       bus.rd_en, 0);
    check("rst_mid_finish",      bus.ctrl_finish, 0);
    repeat (3) @(posedge clk);
    #1 check("rst_held_outputs", {bus.data_o_valid, bus.guard_o_valid, bus.rd_en}, 0);
    @(negedge clk) rst = 1'b0;
    check("rst_no_finish", fin_cnt - f0, 0);
    manual = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NCH; c++) mem[r][c] = rand_psum();
    run_job(1, 1);
    model(1, 1);
    compare_log("rst_restart");

    // Randomized jobs against the stream model
    for (int j = 0; j < 25; j++) begin
      int md, st;
      md = int'($urandom_range(0, 3));
      st = int'($urandom_range(0, 5));
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < NCH; c++) mem[r][c] = rand_psum();
      bp_mode = ($urandom_range(0, 1) == 1);
      run_job(md, st);
      model(md, st);
      compare_log("rand");
    end
    bp_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
